// File: rtl/div3_pkg.sv
// Shared constants and state encoding for the chunked divide-by-3 sequencer.
package div3_pkg;

    localparam int CHUNK_W  = 14;
    localparam int REM_W    = 2;
    localparam int CORE_X_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/div3_seq_ctrl_chk.sv
// Property checker for the sequencer: the core quotient never spills past the chunk width.
module div3_seq_ctrl_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       run,
    input logic [1:0] core_q_top
);

    // With rem < 3 on top, X < 3*2^14, so the two quotient MSBs must be zero.
    a_core_q_top_zero: assert property (@(posedge clk) disable iff (!rst_n)
        run |-> (core_q_top == 2'b00));

endmodule

// File: rtl/div_16_3.sv
// Combinational 16-bit divide-by-3 core: restoring long division, one quotient bit per position.
module div_16_3
    import div3_pkg::*;
(
    input  logic [CORE_X_W-1:0] x,
    output logic [CORE_X_W-1:0] q,
    output logic [REM_W-1:0]    r
);

    logic [REM_W:0]   part_s;
    logic [REM_W-1:0] rem_s;

    // Bit-serial long division unrolled over all 16 positions, MSB first.
    always_comb begin
        q      = {CORE_X_W{1'b0}};
        rem_s  = {REM_W{1'b0}};
        part_s = {(REM_W+1){1'b0}};
        for (int i = CORE_X_W-1; i >= 0; i--) begin
            part_s = {rem_s, x[i]};
            if (part_s >= 3'd3) begin
                q[i]  = 1'b1;
                rem_s = REM_W'(part_s - 3'd3);
            end else begin
                q[i]  = 1'b0;
                rem_s = part_s[REM_W-1:0];
            end
        end
        r = rem_s;
    end

endmodule

// File: rtl/div3_seq_ctrl.sv
// Divides a 14*WORDS-bit operand by 3 one 14-bit chunk per cycle, MSB chunk first,
// with valid/ready handshakes on both sides.
module div3_seq_ctrl
    import div3_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHUNK_W*WORDS-1:0] in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHUNK_W*WORDS-1:0] out_q,
    output logic [REM_W-1:0]         out_r,
    output logic                     busy
);

    localparam int DATA_W = CHUNK_W * WORDS;
    localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

    state_t             state_r, state_nxt_s;
    logic [DATA_W-1:0]  sreg_r, sreg_nxt_s, sreg_step_s;
    logic [REM_W-1:0]   rem_r, rem_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic               out_valid_r, busy_r;
    logic [CORE_X_W-1:0] core_x_s, core_q_s;
    logic [REM_W-1:0]   core_r_s;

    assign core_x_s = {rem_r, sreg_r[DATA_W-1 -: CHUNK_W]};

    div_16_3 u_core (
        .x (core_x_s),
        .q (core_q_s),
        .r (core_r_s)
    );

    // Quotient chunks enter at the bottom as the dividend chunks leave the top.
    generate
        if (WORDS == 1) begin : g_single
            assign sreg_step_s = core_q_s[CHUNK_W-1:0];
        end else begin : g_multi
            assign sreg_step_s = {sreg_r[DATA_W-CHUNK_W-1:0], core_q_s[CHUNK_W-1:0]};
        end
    endgenerate

    // Held low during reset so no producer sees a ready before the block is live.
    assign in_ready = rst_n & ((state_r == S_IDLE) | ((state_r == S_DONE) & out_ready));

    // Next-state and datapath update for the sequencer FSM.
    always_comb begin
        state_nxt_s = state_r;
        sreg_nxt_s  = sreg_r;
        rem_nxt_s   = rem_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = S_RUN;
                    sreg_nxt_s  = in_x;
                    rem_nxt_s   = {REM_W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                sreg_nxt_s = sreg_step_s;
                rem_nxt_s  = core_r_s;
                cnt_nxt_s  = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready && in_valid) begin
                    state_nxt_s = S_RUN;
                    sreg_nxt_s  = in_x;
                    rem_nxt_s   = {REM_W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (out_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                sreg_nxt_s  = {DATA_W{1'b0}};
                rem_nxt_s   = {REM_W{1'b0}};
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, datapath and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            sreg_r      <= {DATA_W{1'b0}};
            rem_r       <= {REM_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            sreg_r      <= sreg_nxt_s;
            rem_r       <= rem_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_valid_r <= (state_nxt_s == S_DONE);
            busy_r      <= (state_nxt_s == S_RUN);
        end
    end

    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_q     = sreg_r;
    assign out_r     = rem_r;

    div3_seq_ctrl_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (state_r == S_RUN),
        .core_q_top (core_q_s[CORE_X_W-1 -: 2])
    );

endmodule

// File: tb/tb_div3_seq_ctrl.sv
// Directed and randomized stimulus for div3_seq_ctrl (WORDS=4) with hand-computed expectations.
module tb_div3_seq_ctrl;

    localparam int WORDS = 4;
    localparam int DW    = 14 * WORDS;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_x;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_q;
    logic [1:0]    out_r;
    logic          busy;

    int checks = 0;
    int errors = 0;

    div3_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Runs one operand from #1 after a rising edge; leaves the bench #1 after an edge in IDLE.
    task automatic do_op(input logic [DW-1:0] x, output logic [DW-1:0] q, output logic [1:0] r,
                         output int lat, output int busy_cnt);
        in_x     = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        q = out_q;
        r = out_r;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_q !== '0)       begin errors++; $display("FAIL reset_out_q got %h want 0", out_q); end
        checks++; if (out_r !== 2'd0)     begin errors++; $display("FAIL reset_out_r got %0d want 0", out_r); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero();
        logic [DW-1:0] q; logic [1:0] r; int lat, bc;
        do_op('0, q, r, lat, bc);
        checks++; if (lat !== 4)   begin errors++; $display("FAIL zero_latency got %0d want 4", lat); end
        checks++; if (q !== '0)    begin errors++; $display("FAIL zero_q got %h want 0", q); end
        checks++; if (r !== 2'd0)  begin errors++; $display("FAIL zero_r got %0d want 0", r); end
    endtask

    task automatic test_hundred();
        logic [DW-1:0] q; logic [1:0] r; int lat, bc;
        do_op(56'd100, q, r, lat, bc);
        checks++; if (q !== 56'd33) begin errors++; $display("FAIL hundred_q got %0d want 33", q); end
        checks++; if (r !== 2'd1)   begin errors++; $display("FAIL hundred_r got %0d want 1", r); end
        checks++; if (bc !== 4)     begin errors++; $display("FAIL hundred_busy_cycles got %0d want 4", bc); end
        checks++; if (lat !== 4)    begin errors++; $display("FAIL hundred_latency got %0d want 4", lat); end
    endtask

    task automatic test_max();
        logic [DW-1:0] q; logic [1:0] r; int lat, bc;
        do_op(56'hFFFFFFFFFFFFFF, q, r, lat, bc);
        checks++; if (q !== 56'h55555555555555) begin errors++; $display("FAIL max_q got %h want 55555555555555", q); end
        checks++; if (r !== 2'd0)               begin errors++; $display("FAIL max_r got %0d want 0", r); end
        do_op(56'hFFFFFFFFFFFFFE, q, r, lat, bc);
        checks++; if (q !== 56'h55555555555554) begin errors++; $display("FAIL maxm1_q got %h want 55555555555554", q); end
        checks++; if (r !== 2'd2)               begin errors++; $display("FAIL maxm1_r got %0d want 2", r); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] q; logic [1:0] r; int lat, bc, wait_cyc;
        in_x     = 56'd1000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_cyc = 0;
        while (!out_valid && wait_cyc < 20) begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_done_timeout out_valid %b want 1", out_valid); end
        in_x     = 56'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
            checks++; if (out_q !== 56'd333)   begin errors++; $display("FAIL bp_q cyc %0d got %0d want 333", i, out_q); end
            checks++; if (out_r !== 2'd1)      begin errors++; $display("FAIL bp_r cyc %0d got %0d want 1", i, out_r); end
            checks++; if (out_valid !== 1'b1)  begin errors++; $display("FAIL bp_valid cyc %0d got %b want 1", i, out_valid); end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_retire_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL bp_same_edge_accept busy got %b want 1", busy); end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (lat !== 4)      begin errors++; $display("FAIL bp_next_latency got %0d want 4", lat); end
        checks++; if (out_q !== 56'd2) begin errors++; $display("FAIL bp_next_q got %0d want 2", out_q); end
        checks++; if (out_r !== 2'd1) begin errors++; $display("FAIL bp_next_r got %0d want 1", out_r); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        q = '0; r = 2'd0; bc = 0;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_q[$];
        logic [1:0]    exp_r[$];
        logic [DW-1:0] eq;
        logic [1:0]    er;
        int sent = 0;
        int recv = 0;
        bit acc;
        for (int cyc = 0; cyc < 3000 && recv < 50; cyc++) begin
            if (!in_valid && sent < 50) begin
                in_x     = {$urandom, $urandom} & {DW{1'b1}};
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q.push_back(in_x / 56'd3);
                exp_r.push_back(2'(in_x % 56'd3));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stream_extra_result got q=%h want none", out_q);
                end else begin
                    eq = exp_q.pop_front();
                    er = exp_r.pop_front();
                    checks++; if (out_q !== eq) begin errors++; $display("FAIL stream_q #%0d got %h want %h", recv, out_q, eq); end
                    checks++; if (out_r !== er) begin errors++; $display("FAIL stream_r #%0d got %0d want %0d", recv, out_r, er); end
                end
                recv++;
            end
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (recv !== 50) begin errors++; $display("FAIL stream_count got %0d want 50", recv); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL stream_leftover got %0d want 0", exp_q.size()); end
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [DW-1:0] q; logic [1:0] r; int lat, bc;
        in_x     = 56'd500;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        checks++; if (out_q !== '0)       begin errors++; $display("FAIL midrst_q got %h want 0", out_q); end
        checks++; if (out_r !== 2'd0)     begin errors++; $display("FAIL midrst_r got %0d want 0", out_r); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_partial got %b want 0", out_valid); end
        do_op(56'd12345, q, r, lat, bc);
        checks++; if (q !== 56'd4115) begin errors++; $display("FAIL midrst_next_q got %0d want 4115", q); end
        checks++; if (r !== 2'd0)     begin errors++; $display("FAIL midrst_next_r got %0d want 0", r); end
        checks++; if (lat !== 4)      begin errors++; $display("FAIL midrst_next_latency got %0d want 4", lat); end
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b0;
        test_reset();
        test_zero();
        test_hundred();
        test_max();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
